// File: rtl/dec_arb_pkg.sv
// Shared constants and state type for the decimator output arbiter.
package dec_arb_pkg;
  localparam int DEF_DATA_W = 24;
  localparam int N_SRC      = 4;
  localparam int SRC_W      = 2;

  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/dec_out_arbiter_rr_grant4.sv
// Combinational 4-way round-robin picker: first request after 'last', wrapping.
module rr_grant4
  import dec_arb_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SRC_W-1:0] last,
  output logic             gnt_vld,
  output logic [SRC_W-1:0] gnt_idx
);

  logic [SRC_W-1:0] idx;

  // Scan farthest offset first so the nearest request overwrites earlier hits.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = last;
    idx     = last;
    for (int k = N_SRC; k >= 1; k--) begin
      idx = last + SRC_W'(k);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/dec_out_arbiter.sv
// Four-source single-word-buffered output arbiter with round-robin grant.
// Optional sticky overrun flags when DEC_ARB_OVF_EN is defined.
module dec_out_arbiter
  import dec_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        in_valid,
  input  logic [N_SRC*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [SRC_W-1:0]        out_src
`ifdef DEC_ARB_OVF_EN
  ,
  input  logic                    ovf_clr,
  output logic [N_SRC-1:0]        ovf
`endif
);

  state_t           state;
  logic [N_SRC-1:0] pend;
  logic [DATA_W-1:0] hold [N_SRC];
  logic [SRC_W-1:0] last_grant;

  logic             gnt_vld;
  logic [SRC_W-1:0] gnt_idx;
  logic             grant;
  logic [N_SRC-1:0] win;
  logic [N_SRC-1:0] cap;

  rr_grant4 u_rr (
    .req     (pend),
    .last    (last_grant),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign grant = gnt_vld && ((state == IDLE) || out_ready);

  // A source being granted frees its slot this cycle, so it may recapture.
  always_comb begin
    win          = '0;
    win[gnt_idx] = grant;
    cap          = in_valid & (~pend | win);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pend       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      last_grant <= SRC_W'(N_SRC - 1);
      for (int i = 0; i < N_SRC; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++)
        if (cap[i]) hold[i] <= in_data[i*DATA_W +: DATA_W];
      pend <= cap | (pend & ~win);
      if (grant) begin
        out_data   <= hold[gnt_idx];
        out_src    <= gnt_idx;
        out_valid  <= 1'b1;
        last_grant <= gnt_idx;
        state      <= SEND;
      end else if (state == SEND && out_ready) begin
        out_valid <= 1'b0;
        state     <= IDLE;
      end
    end
  end

`ifdef DEC_ARB_OVF_EN
  logic [N_SRC-1:0] drop;
  assign drop = in_valid & pend & ~win;

  // A drop coinciding with a clear wins so no overrun goes unreported.
  always_ff @(posedge clk) begin
    if (rst)          ovf <= '0;
    else if (ovf_clr) ovf <= drop;
    else              ovf <= ovf | drop;
  end
`endif

endmodule

// File: tb/tb_dec_out_arbiter.sv
// Self-checking bench for dec_out_arbiter: directed scenarios plus randomized
// traffic against a slot-based behavioural model.
module tb_dec_out_arbiter;
  localparam int DATA_W = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        in_valid;
  logic [4*DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_src;
  logic              ovf_clr;
`ifdef DEC_ARB_OVF_EN
  logic [3:0]        ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dec_out_arbiter #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
`ifdef DEC_ARB_OVF_EN
    ,
    .ovf_clr   (ovf_clr),
    .ovf       (ovf)
`endif
  );

  // Behavioural model: each source owns one slot; output register is issued
  // whenever it is empty or being drained.
  logic              m_full [4];
  logic [DATA_W-1:0] m_word [4];
  logic              m_ov;
  logic [DATA_W-1:0] m_od;
  int                m_os;
  int                m_last;
  logic [3:0]        m_ovf;
  int                m_w;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_full[i] = 1'b0; m_word[i] = '0; end
      m_ov = 1'b0; m_od = '0; m_os = 0; m_last = 3; m_ovf = '0;
    end else begin
      m_w = -1;
      if (!m_ov || out_ready)
        for (int k = 1; k <= 4; k++)
          if (m_w < 0 && m_full[(m_last + k) % 4]) m_w = (m_last + k) % 4;
      if (m_ov && out_ready) m_ov = 1'b0;
      if (m_w >= 0) begin
        m_od = m_word[m_w]; m_os = m_w; m_ov = 1'b1; m_last = m_w; m_full[m_w] = 1'b0;
      end
      if (ovf_clr) m_ovf = '0;
      for (int i = 0; i < 4; i++)
        if (in_valid[i]) begin
          if (!m_full[i]) begin m_full[i] = 1'b1; m_word[i] = in_data[i*DATA_W +: DATA_W]; end
          else m_ovf[i] = 1'b1;
        end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [DATA_W-1:0] w);
    in_data[i*DATA_W +: DATA_W] = w;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_word(i, DATA_W'(24'h500000 + i));
    step();
    in_valid = '0;
    step();
    rst = 1'b1; in_valid = 4'b0010; set_word(1, 24'hDEAD01);
    step();
    rst = 1'b0; in_valid = '0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
    checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL reset_src got=%0d exp=0", out_src); end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_pend_clear cyc=%0d got=%b exp=0", c, out_valid); end
    end
    in_valid = 4'b0011; set_word(0, 24'h0000A0); set_word(1, 24'h0000A1);
    step();
    in_valid = '0;
    step();
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd0) begin errors++; $display("FAIL reset_first_src got=%b/%0d exp=1/0", out_valid, out_src); end
    step(); step();
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    in_valid = 4'b0100; set_word(2, 24'h00ABCD);
    step();
    in_valid = '0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_t1 got=%b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 24'h00ABCD) begin
      errors++; $display("FAIL single_t2 got=%b/%0d/%h exp=1/2/00abcd", out_valid, out_src, out_data); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_t3 got=%b exp=0", out_valid); end
  endtask

  task automatic test_fairness();
    do_reset();
    out_ready = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_word(i, DATA_W'(i + 1));
    step();
    in_valid = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_src !== 2'(i) || out_data !== DATA_W'(i + 1)) begin
        errors++; $display("FAIL fair_%0d got=%b/%0d/%h exp=1/%0d/%h", i, out_valid, out_src, out_data, i, i + 1); end
    end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fair_drop got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    in_valid = 4'b0101; set_word(0, 24'h0000B0); set_word(2, 24'h0000B2);
    step();
    in_valid = '0;
    step();
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 24'h0000B0) begin
        errors++; $display("FAIL bp_hold cyc=%0d got=%b/%0d/%h exp=1/0/0000b0", c, out_valid, out_src, out_data); end
      if (c < 4) step();
    end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 24'h0000B2) begin
      errors++; $display("FAIL bp_next got=%b/%0d/%h exp=1/2/0000b2", out_valid, out_src, out_data); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_end got=%b exp=0", out_valid); end
  endtask

  task automatic test_overrun();
    do_reset();
    out_ready = 1'b0;
    in_valid = 4'b0011; set_word(0, 24'hAAAAAA); set_word(1, 24'h111111);
    step();
    in_valid = 4'b0010; set_word(1, 24'h222222);
    step();
    in_valid = '0;
`ifdef DEC_ARB_OVF_EN
    checks++; if (ovf !== 4'b0010) begin errors++; $display("FAIL ovr_flag got=%b exp=0010", ovf); end
`endif
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 24'h111111) begin
      errors++; $display("FAIL ovr_data got=%b/%0d/%h exp=1/1/111111", out_valid, out_src, out_data); end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_end got=%b exp=0", out_valid); end
`ifdef DEC_ARB_OVF_EN
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL ovr_clr got=%b exp=0000", ovf); end
`endif
  endtask

  task automatic test_capture_on_grant();
    do_reset();
    out_ready = 1'b1;
    in_valid = 4'b1000; set_word(3, 24'h300000);
    step();
    set_word(3, 24'h333333);
    step();
    in_valid = '0;
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd3 || out_data !== 24'h300000) begin
      errors++; $display("FAIL cog_first got=%b/%0d/%h exp=1/3/300000", out_valid, out_src, out_data); end
    step();
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd3 || out_data !== 24'h333333) begin
      errors++; $display("FAIL cog_second got=%b/%0d/%h exp=1/3/333333", out_valid, out_src, out_data); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cog_end got=%b exp=0", out_valid); end
`ifdef DEC_ARB_OVF_EN
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL cog_ovf got=%b exp=0000", ovf); end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
      ovf_clr   = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < 4; i++) set_word(i, DATA_W'($urandom));
      step();
      checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, out_valid, m_ov); end
      if (m_ov) begin
        checks++; if (out_data !== m_od || out_src !== 2'(m_os)) begin
          errors++; $display("FAIL rnd_word cyc=%0d got=%0d/%h exp=%0d/%h", c, out_src, out_data, m_os, m_od); end
      end
`ifdef DEC_ARB_OVF_EN
      checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", c, ovf, m_ovf); end
`endif
    end
    rst = 1'b0; in_valid = '0; ovf_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_overrun();
    test_capture_on_grant();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
